hdc_fold_scheduler: RTL and testbench

Control FSM that sequences one classification through the folded HDC sensor-fusion datapath. It accepts a feature vector over the top-level `fin_valid`/`fin_ready` handshake, then issues `NUM_FOLDS` encoder passes, each followed by a push of that folded query slice into the associative memory. It captures the valence/arousal result and presents it over `dout_valid`/`dout_ready`. It sits between the top-level ports of `hdc_sensor_fusion` and the rule-90 item-memory generator, spatial/temporal encoder and AM datapath, and owns no hypervector storage itself.

---
 rtl/hdc_fold_scheduler.sv | 152 +++++++++++++++
 tb/tb_hdc_fold_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_fold_scheduler.sv
// Control sequencer for one folded HDC classification: feature accept,
// NUM_FOLDS encoder/AM passes, result capture and hand-off with latency report.
module hdc_fold_scheduler #(
  parameter int unsigned NUM_FOLDS  = 10,
  parameter int unsigned FOLD_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fin_valid,
  output logic                  fin_ready,
  output logic                  feature_load,
  output logic                  enc_start,
  output logic [FOLD_WIDTH-1:0] enc_fold_idx,
  output logic                  im_seed_load,
  input  logic                  enc_done,
  output logic                  am_valid,
  input  logic                  am_ready,
  output logic                  am_last,
  input  logic                  am_res_valid,
  input  logic                  am_valence,
  input  logic                  am_arousal,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  valence,
  output logic                  arousal,
  output logic [CNT_WIDTH-1:0]  last_latency
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ENC,
    S_PUSH,
    S_WAIT_RES,
    S_OUT
  } state_t;

  localparam logic [FOLD_WIDTH-1:0] LAST_FOLD = FOLD_WIDTH'(NUM_FOLDS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t                state_q;
  logic [FOLD_WIDTH-1:0] fold_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  fin_ready_q;
  logic                  enc_start_q;
  logic                  im_seed_load_q;
  logic                  am_valid_q;
  logic                  am_last_q;
  logic                  dout_valid_q;
  logic                  valence_q;
  logic                  arousal_q;
  logic [CNT_WIDTH-1:0]  last_latency_q;

  // Saturating elapsed-cycle count, also the value reported at the dout handshake
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Accept stays closed while reset is asserted so no feature load can slip through
  assign fin_ready    = fin_ready_q && !rst;
  assign feature_load = fin_valid && fin_ready;

  assign enc_start    = enc_start_q;
  assign enc_fold_idx = fold_q;
  assign im_seed_load = im_seed_load_q;
  assign am_valid     = am_valid_q;
  assign am_last      = am_last_q;
  assign dout_valid   = dout_valid_q;
  assign valence      = valence_q;
  assign arousal      = arousal_q;
  assign last_latency = last_latency_q;

  // Sequencer state, fold index, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fold_q         <= '0;
      cnt_q          <= '0;
      fin_ready_q    <= 1'b1;
      enc_start_q    <= 1'b0;
      im_seed_load_q <= 1'b0;
      am_valid_q     <= 1'b0;
      am_last_q      <= 1'b0;
      dout_valid_q   <= 1'b0;
      valence_q      <= 1'b0;
      arousal_q      <= 1'b0;
      last_latency_q <= '0;
    end else begin
      enc_start_q    <= 1'b0;
      im_seed_load_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= cnt_inc;
      end
      case (state_q)
        S_IDLE: begin
          if (fin_valid) begin
            fold_q         <= '0;
            cnt_q          <= '0;
            fin_ready_q    <= 1'b0;
            enc_start_q    <= 1'b1;
            im_seed_load_q <= 1'b1;
            state_q        <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT_ENC;
        end
        S_WAIT_ENC: begin
          if (enc_done) begin
            am_valid_q <= 1'b1;
            am_last_q  <= (fold_q == LAST_FOLD);
            state_q    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (am_ready) begin
            am_valid_q <= 1'b0;
            am_last_q  <= 1'b0;
            if (am_last_q) begin
              state_q <= S_WAIT_RES;
            end else begin
              fold_q      <= fold_q + FOLD_WIDTH'(1);
              enc_start_q <= 1'b1;
              state_q     <= S_START;
            end
          end
        end
        S_WAIT_RES: begin
          if (am_res_valid) begin
            valence_q    <= am_valence;
            arousal_q    <= am_arousal;
            dout_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end
        end
        S_OUT: begin
          if (dout_ready) begin
            dout_valid_q   <= 1'b0;
            last_latency_q <= cnt_inc;
            fin_ready_q    <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          fin_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_fold_scheduler.sv
// Bench for hdc_fold_scheduler: timeline model of each classification built
// from per-fold responder delays, plus a single-fold instance for edge cases.
module tb_hdc_fold_scheduler;

  localparam int unsigned NF  = 4;
  localparam int unsigned FW  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fin_valid, fin_ready, feature_load, enc_start, im_seed_load, enc_done;
  logic [FW-1:0] enc_fold_idx;
  logic          am_valid, am_ready, am_last, am_res_valid, am_valence, am_arousal;
  logic          dout_valid, dout_ready, valence, arousal;
  logic [CW-1:0] last_latency;

  logic           b_fin_valid, b_fin_ready, b_feature_load, b_enc_start, b_im_seed_load, b_enc_done;
  logic [0:0]     b_enc_fold_idx;
  logic           b_am_valid, b_am_ready, b_am_last, b_am_res_valid, b_am_valence, b_am_arousal;
  logic           b_dout_valid, b_dout_ready, b_valence, b_arousal;
  logic [CW1-1:0] b_last_latency;

  hdc_fold_scheduler #(.NUM_FOLDS(NF), .FOLD_WIDTH(FW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .feature_load(feature_load), .enc_start(enc_start), .enc_fold_idx(enc_fold_idx),
    .im_seed_load(im_seed_load), .enc_done(enc_done), .am_valid(am_valid),
    .am_ready(am_ready), .am_last(am_last), .am_res_valid(am_res_valid),
    .am_valence(am_valence), .am_arousal(am_arousal), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .valence(valence), .arousal(arousal),
    .last_latency(last_latency)
  );

  hdc_fold_scheduler #(.NUM_FOLDS(1), .FOLD_WIDTH(1), .CNT_WIDTH(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .fin_valid(b_fin_valid), .fin_ready(b_fin_ready),
    .feature_load(b_feature_load), .enc_start(b_enc_start), .enc_fold_idx(b_enc_fold_idx),
    .im_seed_load(b_im_seed_load), .enc_done(b_enc_done), .am_valid(b_am_valid),
    .am_ready(b_am_ready), .am_last(b_am_last), .am_res_valid(b_am_res_valid),
    .am_valence(b_am_valence), .am_arousal(b_am_arousal), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready), .valence(b_valence), .arousal(b_arousal),
    .last_latency(b_last_latency)
  );

  int checks = 0;
  int errors = 0;
  int cur_t  = 0;

  // Per-classification scenario knobs
  int   ew[NF];
  int   aw[NF];
  int   rw, dw, spur_enc, spur_res, abort_fold;
  logic lab_v, lab_a;

  // Model state carried between classifications
  int   exp_idx_idle;
  logic prev_v, prev_a;
  int   prev_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, want);
    end
  endtask

  task automatic chk_all(input bit e_fr, input bit e_fl, input bit e_es, input bit e_sl,
                         input int e_idx, input bit e_av, input bit e_al, input bit e_dv,
                         input bit e_v, input bit e_a, input int e_lat);
    chk("fin_ready",    32'(fin_ready),    32'(e_fr));
    chk("feature_load", 32'(feature_load), 32'(e_fl));
    chk("enc_start",    32'(enc_start),    32'(e_es));
    chk("im_seed_load", 32'(im_seed_load), 32'(e_sl));
    chk("enc_fold_idx", 32'(enc_fold_idx), 32'(e_idx));
    chk("am_valid",     32'(am_valid),     32'(e_av));
    chk("am_last",      32'(am_last),      32'(e_al));
    chk("dout_valid",   32'(dout_valid),   32'(e_dv));
    chk("valence",      32'(valence),      32'(e_v));
    chk("arousal",      32'(arousal),      32'(e_a));
    chk("last_latency", 32'(last_latency), 32'(e_lat));
  endtask

  task automatic chk1_all(input bit e_fr, input bit e_es, input bit e_av, input bit e_dv,
                          input bit e_v, input int e_lat);
    chk("n1_fin_ready",    32'(b_fin_ready),    32'(e_fr));
    chk("n1_feature_load", 32'(b_feature_load), 32'(e_fr && b_fin_valid));
    chk("n1_enc_start",    32'(b_enc_start),    32'(e_es));
    chk("n1_im_seed_load", 32'(b_im_seed_load), 32'(e_es));
    chk("n1_enc_fold_idx", 32'(b_enc_fold_idx), 32'(0));
    chk("n1_am_valid",     32'(b_am_valid),     32'(e_av));
    chk("n1_am_last",      32'(b_am_last),      32'(e_av));
    chk("n1_dout_valid",   32'(b_dout_valid),   32'(e_dv));
    chk("n1_valence",      32'(b_valence),      32'(e_v));
    chk("n1_arousal",      32'(b_arousal),      32'(0));
    chk("n1_last_latency", 32'(b_last_latency), 32'(e_lat));
  endtask

  task automatic idle_inputs();
    fin_valid = 1'b0; enc_done = 1'b0; am_ready = 1'b0; am_res_valid = 1'b0;
    am_valence = 1'b0; am_arousal = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic defaults();
    for (int k = 0; k < NF; k++) begin
      ew[k] = 0;
      aw[k] = 0;
    end
    rw = 0; dw = 0; spur_enc = -1; spur_res = -1; abort_fold = -1;
    lab_v = 1'b1; lab_a = 1'b0;
  endtask

  // One classification driven on a precomputed timeline; expected outputs follow
  // from the fold start / push window / result / output cycles of that timeline.
  task automatic run_class();
    int st[NF];
    int ps[NF];
    int pe[NF];
    int c, t_ws, t_os, lat, abort_t, k_cur;
    bit ed, ar, rv, rv_real, e_es, e_sl, e_av, e_al;
    c = 1;
    for (int k = 0; k < NF; k++) begin
      st[k] = c;
      ps[k] = c + 2 + ew[k];
      pe[k] = ps[k] + aw[k];
      c     = pe[k] + 1;
    end
    t_ws    = c;
    t_os    = c + 1 + rw;
    lat     = t_os + dw;
    abort_t = (abort_fold >= 0) ? ps[abort_fold] + 1 : -1;
    for (int t = 0; t <= lat; t++) begin
      cur_t = t;
      ed = 1'b0; ar = 1'b0; rv = 1'b0; e_es = 1'b0; e_av = 1'b0; e_al = 1'b0;
      e_sl  = (t == st[0]);
      k_cur = (t == 0) ? exp_idx_idle : 0;
      for (int k = 0; k < NF; k++) begin
        if (t == st[k] + 1 + ew[k] || (k == spur_enc && t == st[k])) ed = 1'b1;
        if (t == pe[k]) ar = 1'b1;
        if (k == spur_res && t == st[k] + 1) rv = 1'b1;
        if (t == st[k]) e_es = 1'b1;
        if (t >= st[k]) k_cur = k;
        if (t >= ps[k] && t <= pe[k]) begin
          e_av = 1'b1;
          e_al = (k == NF - 1);
        end
      end
      rv_real      = (t == t_ws + rw);
      fin_valid    = (t == 0);
      enc_done     = ed;
      am_ready     = ar;
      am_res_valid = rv || rv_real;
      am_valence   = rv_real ? lab_v : ~lab_v;
      am_arousal   = rv_real ? lab_a : ~lab_a;
      dout_ready   = (t == lat);
      rst          = (t == abort_t);
      #1;
      chk_all(t == 0, t == 0, e_es, e_sl, k_cur, e_av, e_al, t >= t_os,
              (t >= t_os) ? lab_v : prev_v, (t >= t_os) ? lab_a : prev_a, prev_lat);
      @(posedge clk);
      #1;
      if (t == abort_t) begin
        rst = 1'b0;
        idle_inputs();
        #1;
        cur_t = t + 1;
        chk_all(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        exp_idx_idle = 0; prev_v = 1'b0; prev_a = 1'b0; prev_lat = 0;
        return;
      end
    end
    idle_inputs();
    #1;
    cur_t = lat + 1;
    chk_all(1'b1, 1'b0, 1'b0, 1'b0, NF - 1, 1'b0, 1'b0, 1'b0, lab_v, lab_a, lat);
    exp_idx_idle = NF - 1; prev_v = lab_v; prev_a = lab_a; prev_lat = lat;
  endtask

  initial begin
    int sat_lat;
    rst = 1'b1;
    idle_inputs();
    fin_valid = 1'b1;
    b_fin_valid = 1'b0; b_enc_done = 1'b0; b_am_ready = 1'b0; b_am_res_valid = 1'b0;
    b_am_valence = 1'b0; b_am_arousal = 1'b0; b_dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cur_t = -1;
    // Held in reset with fin_valid high: nothing accepted, all outputs quiet
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("n1_fin_ready_rst", 32'(b_fin_ready), 32'(0));
    rst = 1'b0;
    fin_valid = 1'b0;
    #1;
    cur_t = 0;
    chk_all(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    exp_idx_idle = 0; prev_v = 1'b0; prev_a = 1'b0; prev_lat = 0;

    // Immediate responders
    defaults();
    run_class();

    // Encoder stall on fold 2 with a stray enc_done during its START
    defaults();
    ew[2] = 4; spur_enc = 2; lab_v = 1'b0; lab_a = 1'b1;
    run_class();

    // AM backpressure on fold 0 and output backpressure
    defaults();
    aw[0] = 3; dw = 6; lab_v = 1'b1; lab_a = 1'b1;
    run_class();

    // Back-to-back random classifications with stray am_res_valid in WAIT_ENC
    for (int n = 0; n < 20; n++) begin
      defaults();
      for (int k = 0; k < NF; k++) begin
        ew[k] = $urandom_range(0, 2);
        aw[k] = $urandom_range(0, 2);
      end
      rw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      spur_res = $urandom_range(0, NF - 1);
      lab_v = 1'($urandom);
      lab_a = 1'($urandom);
      run_class();
    end

    // Reset during the fold-2 push, then a clean classification
    defaults();
    aw[2] = 3; abort_fold = 2;
    run_class();
    defaults();
    lab_v = 1'b0; lab_a = 1'b1;
    run_class();

    // Single-fold instance, all responders held high, two back-to-back runs
    b_fin_valid = 1'b1; b_enc_done = 1'b1; b_am_ready = 1'b1; b_am_res_valid = 1'b1;
    b_dout_ready = 1'b1; b_am_valence = 1'b1; b_am_arousal = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cur_t = 100 + t;
      #1;
      chk1_all((t % 6) == 0, (t % 6) == 1, (t % 6) == 3, (t % 6) == 5, t >= 5, (t < 6) ? 0 : 5);
      @(posedge clk);
      #1;
    end

    // Output held off long enough for the narrow latency counter to saturate
    b_dout_ready = 1'b0;
    sat_lat = (25 > 15) ? 15 : 25;
    for (int t = 0; t <= 25; t++) begin
      cur_t = 200 + t;
      b_fin_valid  = (t == 0);
      b_dout_ready = (t == 25);
      #1;
      chk1_all(t == 0, t == 1, t == 3, t >= 5, 1'b1, 5);
      @(posedge clk);
      #1;
    end
    b_fin_valid = 1'b0;
    b_dout_ready = 1'b0;
    #1;
    cur_t = 226;
    chk1_all(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sat_lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
